// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM datapath opcode enum, flag struct and opcode-class helper
package arm_pkg;
  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } op_t;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  // 2..7 and A..B go through the adder; everything else is logical
  function automatic logic is_arith(input logic [3:0] op);
    return (op[3:1] == 3'b001) || (op[3:2] == 2'b01) || (op[3:1] == 3'b101);
  endfunction
endpackage

// File: rtl/alu_flags_if.sv
// alu_flags_if: ALU operand/opcode bus and result/flag returns; master drives operands, slave is the ALU
interface alu_flags_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        sr_load;
  logic [31:0] result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        sr_n, sr_z, sr_c, sr_v;
  modport master (
    output a, b, op, sr_load,
    input  result, alu_n, alu_z, alu_c, alu_v, sr_n, sr_z, sr_c, sr_v
  );
  modport slave (
    input  a, b, op, sr_load,
    output result, alu_n, alu_z, alu_c, alu_v, sr_n, sr_z, sr_c, sr_v
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational 32-bit ARM ALU; ports a, b, op, cin in; result, n, z, c, v out (c/v are adder flags)
import arm_pkg::*;
module alu_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic        cin,
  output logic [31:0] result,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);
  logic        w_rev, w_sub, w_cin;
  logic [31:0] w_x, w_y;
  logic [32:0] w_sum;
  always_comb begin
    w_rev = (op == OP_RSB) || (op == OP_RSC);
    w_sub = (op == OP_SUB) || (op == OP_RSB) || (op == OP_SBC) || (op == OP_RSC) || (op == OP_CMP);
    w_cin = (op == OP_ADC) || (op == OP_SBC) || (op == OP_RSC) ? cin : w_sub;
    w_x = w_rev ? b : a;
    w_y = w_sub ? ~(w_rev ? a : b) : b;
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
    case (op)
      OP_AND, OP_TST: result = a & b;
      OP_EOR, OP_TEQ: result = a ^ b;
      OP_ORR:         result = a | b;
      OP_MOV:         result = b;
      OP_BIC:         result = a & ~b;
      OP_MVN:         result = ~b;
      default:        result = w_sum[31:0];
    endcase
    n = result[31];
    z = result == 32'd0;
    c = w_sum[32];
    v = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
  end
endmodule

// File: rtl/alu_flags.sv
// alu_flags: ARM ALU plus registered NZCV status; CLK, reset (async active-low), bus slave modport; ALU_CARRY_OPS_EN enables ADC/SBC/RSC carry-in
import arm_pkg::*;
module alu_flags (
  input  logic        CLK,
  input  logic        reset,
  alu_flags_if.slave  bus
);
  flags_t      r_sr;
  flags_t      w_fl;
  logic        w_cin, w_n, w_z, w_c, w_v;
  logic [31:0] w_res;
`ifdef ALU_CARRY_OPS_EN
  assign w_cin = r_sr.c;
`else
  // carry ops collapse onto ADD (cin 0) and SUB/RSB (cin 1)
  assign w_cin = bus.op != OP_ADC;
`endif
  alu_core u_core (
    .a(bus.a), .b(bus.b), .op(bus.op), .cin(w_cin),
    .result(w_res), .n(w_n), .z(w_z), .c(w_c), .v(w_v)
  );
  always_comb begin
    w_fl.n = w_n;
    w_fl.z = w_z;
    w_fl.c = is_arith(bus.op) ? w_c : r_sr.c;
    w_fl.v = is_arith(bus.op) ? w_v : r_sr.v;
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) r_sr <= '0;
    else if (bus.sr_load) r_sr <= w_fl;
  assign bus.result = w_res;
  assign {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = w_fl;
  assign {bus.sr_n, bus.sr_z, bus.sr_c, bus.sr_v} = r_sr;
endmodule

// File: tb/tb_alu_flags.sv
// tb_alu_flags: directed vectors with a queued scoreboard checked by a negedge monitor
import arm_pkg::*;
module tb_alu_flags;
  logic CLK = 0;
  logic reset = 0;
  alu_flags_if bus ();
  alu_flags dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        chk_res;
    logic [31:0] res;
    logic [3:0]  amask;
    logic [3:0]  aval;
    logic [3:0]  smask;
    logic [3:0]  sval;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ld);
    @(posedge CLK);
    #1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.sr_load = ld;
  endtask

  task automatic push(input string nm, input logic cr, input logic [31:0] r,
                      input logic [3:0] am, input logic [3:0] av,
                      input logic [3:0] sm, input logic [3:0] sv);
    exp_t e;
    e.name = nm; e.chk_res = cr; e.res = r;
    e.amask = am; e.aval = av; e.smask = sm; e.sval = sv;
    q.push_back(e);
  endtask

  initial begin
    logic [3:0] a_act, s_act;
    exp_t e;
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        e = q.pop_front();
        a_act = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        s_act = {bus.sr_n, bus.sr_z, bus.sr_c, bus.sr_v};
        if (e.chk_res) begin
          checks++;
          if (bus.result !== e.res) begin
            errors++;
            $display("FAIL %s result got %h want %h", e.name, bus.result, e.res);
          end
        end
        if (e.amask != 0) begin
          checks++;
          if ((a_act & e.amask) !== (e.aval & e.amask)) begin
            errors++;
            $display("FAIL %s alu_nzcv got %b want %b mask %b", e.name, a_act, e.aval, e.amask);
          end
        end
        if (e.smask != 0) begin
          checks++;
          if ((s_act & e.smask) !== (e.sval & e.smask)) begin
            errors++;
            $display("FAIL %s sr_nzcv got %b want %b mask %b", e.name, s_act, e.sval, e.smask);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = OP_AND; bus.a = 0; bus.b = 0; bus.sr_load = 0;
    #2;
    push("reset_state", 0, 0, 4'h0, 4'h0, 4'hF, 4'b0000);
    @(posedge CLK);
    #1 reset = 1;
    drive(OP_ADD, 5, 3, 1);
    push("add_5_3", 1, 8, 4'hF, 4'b0000, 4'hF, 4'b0000);
    drive(OP_CMP, 3, 3, 1);
    push("cmp_eq", 1, 0, 4'hF, 4'b0110, 4'hF, 4'b0000);
    drive(OP_ADD, 32'h7FFF_FFFF, 1, 0);
    push("add_ovf", 1, 32'h8000_0000, 4'hF, 4'b1001, 4'hF, 4'b0110);
    drive(OP_ADD, 32'hFFFF_FFFF, 1, 1);
    push("add_wrap", 1, 0, 4'hF, 4'b0110, 4'hF, 4'b0110);
`ifdef ALU_CARRY_OPS_EN
    drive(OP_ADC, 0, 0, 0);
    push("adc_c1", 1, 1, 4'hF, 4'b0000, 4'hF, 4'b0110);
`else
    drive(OP_ADC, 0, 0, 0);
    push("adc_as_add", 1, 0, 4'hF, 4'b0100, 4'hF, 4'b0110);
`endif
    drive(OP_SUB, 32'h8000_0000, 1, 1);
    push("sub_ovf", 1, 32'h7FFF_FFFF, 4'hF, 4'b0011, 4'hF, 4'b0110);
    drive(OP_BIC, 32'hFF, 32'h0F, 0);
    push("bic", 1, 32'hF0, 4'hF, 4'b0011, 4'hF, 4'b0011);
    drive(OP_MVN, 0, 0, 0);
    push("mvn", 1, 32'hFFFF_FFFF, 4'hF, 4'b1011, 4'hF, 4'b0011);
    drive(OP_EOR, 32'hF0F0, 32'hFF00, 0);
    push("eor", 1, 32'h0FF0, 4'hF, 4'b0011, 4'h0, 4'h0);
    drive(OP_ORR, 1, 2, 0);
    push("orr", 1, 3, 4'hF, 4'b0011, 4'h0, 4'h0);
    drive(OP_MOV, 32'hABCD, 0, 0);
    push("mov_zero", 1, 0, 4'hF, 4'b0111, 4'h0, 4'h0);
    drive(OP_TST, 32'hF0, 32'h3C, 0);
    push("tst", 1, 32'h30, 4'hF, 4'b0011, 4'h0, 4'h0);
    drive(OP_RSB, 3, 10, 0);
    push("rsb", 1, 7, 4'hF, 4'b0010, 4'h0, 4'h0);
    drive(OP_RSC, 3, 10, 0);
    push("rsc_c1", 1, 7, 4'hF, 4'b0010, 4'h0, 4'h0);
    drive(OP_CMN, 32'hFFFF_FFFF, 1, 0);
    push("cmn", 1, 0, 4'hF, 4'b0110, 4'h0, 4'h0);
    drive(OP_CMP, 3, 3, 1);
    push("cmp_load_z", 1, 0, 4'hF, 4'b0110, 4'hF, 4'b0011);
    drive(OP_ADD, 1, 1, 0);
    push("sr_z_set", 1, 2, 4'h0, 4'h0, 4'hF, 4'b0110);
    drive(OP_ADC, 0, 0, 1);
    #2 reset = 0;
    push("async_reset", 1, 0, 4'hF, 4'b0100, 4'hF, 4'b0000);
    drive(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1);
    push("reset_over_load", 1, 0, 4'hF, 4'b0111, 4'hF, 4'b0000);
    @(posedge CLK);
    #1 reset = 1;
    push("first_edge_pre", 0, 0, 4'hF, 4'b0111, 4'hF, 4'b0000);
    drive(OP_AND, 0, 0, 0);
    push("first_edge_load", 1, 0, 4'h0, 4'h0, 4'hF, 4'b0111);
    drive(OP_MVN, 0, 0, 0);
    push("hold_1", 1, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'hF, 4'b0111);
    drive(OP_SUB, 5, 1, 0);
    push("hold_2", 1, 4, 4'h0, 4'h0, 4'hF, 4'b0111);
    drive(OP_ORR, 1, 0, 0);
    push("hold_3", 1, 1, 4'h0, 4'h0, 4'hF, 4'b0111);
    @(posedge CLK);
    @(posedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
